// File: rtl/dcache_responder_if.sv
// CPU data port and single-outstanding memory port of the data-cache responder.
// The slave modport is the cache view; the master modport is the CPU/memory environment view.
interface dcache_responder_if;
  logic [31:0] cpu_raddr_i;
  logic        cpu_rreq_i;
  logic [31:0] cpu_waddr_i;
  logic [31:0] cpu_wdata_i;
  logic [3:0]  cpu_wsel_i;
  logic        cpu_wreq_i;
  logic [31:0] cpu_rdata_o;
  logic        cpu_done_o;
  logic        cpu_busy_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wsel_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  modport slave (
    input  cpu_raddr_i, cpu_rreq_i, cpu_waddr_i, cpu_wdata_i, cpu_wsel_i, cpu_wreq_i,
    input  mem_rdata_i, mem_ack_i,
    output cpu_rdata_o, cpu_done_o, cpu_busy_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wsel_o
  );

  modport master (
    output cpu_raddr_i, cpu_rreq_i, cpu_waddr_i, cpu_wdata_i, cpu_wsel_i, cpu_wreq_i,
    output mem_rdata_i, mem_ack_i,
    input  cpu_rdata_o, cpu_done_o, cpu_busy_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wsel_o
  );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data cache responder.
// Define DCACHE_STATS_EN to enable the read hit/miss counters (otherwise tied to 0).
module dcache_responder #(
  parameter int unsigned INDEX_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  dcache_responder_if.slave        bus,
  output logic [31:0]              hit_cnt_o,
  output logic [31:0]              miss_cnt_o
);
  localparam int unsigned TAG_W = 32 - INDEX_W;
  localparam int unsigned Lines = 1 << INDEX_W;

  typedef enum logic [1:0] {StIdle, StWrMem, StRdMem} state_e;

  state_e            state_q, state_d;
  logic              valid_q [Lines];
  logic [TAG_W-1:0]  tag_q   [Lines];
  logic [31:0]       data_q  [Lines];

  logic [31:0] raddr_q, raddr_d;
  logic        pend_q, pend_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        mreq_q, mreq_d, mwe_q, mwe_d;
  logic [31:0] maddr_q, maddr_d, mwdata_q, mwdata_d;
  logic [3:0]  mwsel_q, mwsel_d;

  logic [INDEX_W-1:0] ridx, widx, pidx;
  logic               rhit, whit, phit;
  logic [31:0]        merged;
  logic               line_we, fill;
  logic [INDEX_W-1:0] line_idx;
  logic [TAG_W-1:0]   line_tag;
  logic [31:0]        line_data;

  assign ridx = bus.cpu_raddr_i[INDEX_W-1:0];
  assign widx = bus.cpu_waddr_i[INDEX_W-1:0];
  assign pidx = raddr_q[INDEX_W-1:0];
  assign rhit = valid_q[ridx] && (tag_q[ridx] == bus.cpu_raddr_i[31:INDEX_W]);
  assign whit = valid_q[widx] && (tag_q[widx] == bus.cpu_waddr_i[31:INDEX_W]);
  assign phit = valid_q[pidx] && (tag_q[pidx] == raddr_q[31:INDEX_W]);

  always_comb begin
    merged = data_q[widx];
    for (int b = 0; b < 4; b++) begin
      if (bus.cpu_wsel_i[b]) merged[8*b +: 8] = bus.cpu_wdata_i[8*b +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    raddr_d  = raddr_q;
    pend_d   = pend_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    mreq_d   = mreq_q;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mwsel_d  = mwsel_q;
    line_we  = 1'b0;
    fill     = 1'b0;
    line_idx = widx;
    line_tag = bus.cpu_waddr_i[31:INDEX_W];
    line_data = merged;
    unique case (state_q)
      StIdle: begin
        if (bus.cpu_wreq_i) begin
          state_d  = StWrMem;
          mreq_d   = 1'b1;
          mwe_d    = 1'b1;
          maddr_d  = bus.cpu_waddr_i;
          mwdata_d = bus.cpu_wdata_i;
          mwsel_d  = bus.cpu_wsel_i;
          pend_d   = bus.cpu_rreq_i;
          raddr_d  = bus.cpu_raddr_i;
          line_we  = whit;
        end else if (bus.cpu_rreq_i) begin
          raddr_d = bus.cpu_raddr_i;
          if (rhit) begin
            done_d  = 1'b1;
            rdata_d = data_q[ridx];
          end else begin
            state_d  = StRdMem;
            mreq_d   = 1'b1;
            mwe_d    = 1'b0;
            maddr_d  = bus.cpu_raddr_i;
            mwdata_d = '0;
            mwsel_d  = '0;
          end
        end
      end
      StWrMem: begin
        if (bus.mem_ack_i) begin
          mreq_d = 1'b0;
          mwe_d  = 1'b0;
          pend_d = 1'b0;
          if (!pend_q || phit) begin
            state_d = StIdle;
            done_d  = 1'b1;
            if (pend_q) rdata_d = data_q[pidx];
          end else begin
            // Request re-issued one cycle later so mem_* never change under a held request.
            state_d  = StRdMem;
            maddr_d  = raddr_q;
            mwdata_d = '0;
            mwsel_d  = '0;
          end
        end
      end
      StRdMem: begin
        if (!mreq_q) begin
          mreq_d = 1'b1;
        end else if (bus.mem_ack_i) begin
          state_d   = StIdle;
          mreq_d    = 1'b0;
          done_d    = 1'b1;
          rdata_d   = bus.mem_rdata_i;
          line_we   = 1'b1;
          fill      = 1'b1;
          line_idx  = pidx;
          line_tag  = raddr_q[31:INDEX_W];
          line_data = bus.mem_rdata_i;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      raddr_q  <= '0;
      pend_q   <= 1'b0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mwsel_q  <= '0;
      for (int i = 0; i < Lines; i++) valid_q[i] <= 1'b0;
    end else begin
      state_q  <= state_d;
      raddr_q  <= raddr_d;
      pend_q   <= pend_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mwsel_q  <= mwsel_d;
      if (fill) valid_q[line_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && line_we) begin
      tag_q[line_idx]  <= line_tag;
      data_q[line_idx] <= line_data;
    end
  end

  assign bus.cpu_rdata_o = rdata_q;
  assign bus.cpu_done_o  = done_q;
  assign bus.cpu_busy_o  = (state_q != StIdle);
  assign bus.mem_req_o   = mreq_q;
  assign bus.mem_we_o    = mwe_q;
  assign bus.mem_addr_o  = maddr_q;
  assign bus.mem_wdata_o = mwdata_q;
  assign bus.mem_wsel_o  = mwsel_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        hit_inc, miss_inc, rd_only, wr_ack_pend;

  assign rd_only     = (state_q == StIdle) && bus.cpu_rreq_i && !bus.cpu_wreq_i;
  assign wr_ack_pend = (state_q == StWrMem) && bus.mem_ack_i && pend_q;
  assign hit_inc     = (rd_only && rhit) || (wr_ack_pend && phit);
  assign miss_inc    = (rd_only && !rhit) || (wr_ack_pend && !phit);

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_inc)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_inc) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif
endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench for dcache_responder: directed CPU traffic against a latency-configurable
// memory model; completions are checked by a separate monitor.
module tb_dcache_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_responder_if bus ();
  logic [31:0] hit_cnt, miss_cnt;

  dcache_responder #(.INDEX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .hit_cnt_o (hit_cnt),
    .miss_cnt_o(miss_cnt)
  );

  typedef struct {
    bit          is_read;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_model [int unsigned];
  int          mem_rd_cnt = 0;
  int          mem_wr_cnt = 0;
  logic [3:0]  last_wsel = 4'hf;
  int          lat = 3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : 32'h0;
  endfunction

  // Completion monitor
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.cpu_done_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 expected no completion");
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_read) chk("sb_rdata", bus.cpu_rdata_o, mon_e.data);
      end
    end
  end

  // Memory model: acks after `lat` cycles, checks request stability while held
  initial begin : mem_proc
    logic        we;
    logic [31:0] a, wd, cur;
    logic [3:0]  ws;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req_o === 1'b1) begin
        we = bus.mem_we_o;
        a  = bus.mem_addr_o;
        wd = bus.mem_wdata_o;
        ws = bus.mem_wsel_o;
        for (int i = 1; i < lat; i++) begin
          @(negedge clk);
          if (bus.mem_req_o === 1'b1) chk("mem_addr_stable", bus.mem_addr_o, a);
        end
        if (we) begin
          mem_wr_cnt++;
          last_wsel = ws;
          cur = mem_rd(a);
          for (int b = 0; b < 4; b++) if (ws[b]) cur[8*b +: 8] = wd[8*b +: 8];
          mem_model[a] = cur;
        end else begin
          mem_rd_cnt++;
          bus.mem_rdata_i = mem_rd(a);
        end
        bus.mem_ack_i = 1'b1;
        @(negedge clk);
        bus.mem_ack_i = 1'b0;
      end
    end
  end

  task automatic issue(input bit rr, input logic [31:0] ra, input bit wr, input logic [31:0] wa,
                       input logic [31:0] wd, input logic [3:0] ws);
    int n;
    @(negedge clk);
    for (n = 0; bus.cpu_busy_o && n < 200; n++) @(negedge clk);
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy=1 expected idle within 200 cycles");
    end
    bus.cpu_rreq_i  = rr;
    bus.cpu_raddr_i = ra;
    bus.cpu_wreq_i  = wr;
    bus.cpu_waddr_i = wa;
    bus.cpu_wdata_i = wd;
    bus.cpu_wsel_i  = ws;
    @(negedge clk);
    bus.cpu_rreq_i  = 1'b0;
    bus.cpu_wreq_i  = 1'b0;
    bus.cpu_raddr_i = 32'hffff_ffff;
    bus.cpu_waddr_i = 32'hffff_ffff;
    bus.cpu_wdata_i = 32'h5a5a_5a5a;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    sb.push_back('{is_read: 1'b1, data: exp});
    issue(1'b1, a, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    sb.push_back('{is_read: 1'b0, data: 32'h0});
    issue(1'b0, 32'h0, 1'b1, a, d, s);
  endtask

  task automatic wait_done(input string name);
    int n;
    for (n = 0; (sb.size() != 0 || bus.cpu_busy_o) && n < 200; n++) @(negedge clk);
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    mem_model[32'h3]  = 32'h0000_1234;
    mem_model[32'h2]  = 32'h1122_3344;
    mem_model[32'h7]  = 32'h0000_0000;
    mem_model[32'h1]  = 32'h0101_0101;
    mem_model[32'h11] = 32'h1111_1111;
    rst = 1'b1;
    bus.cpu_rreq_i = 1'b0; bus.cpu_raddr_i = '0;
    bus.cpu_wreq_i = 1'b0; bus.cpu_waddr_i = '0;
    bus.cpu_wdata_i = '0;  bus.cpu_wsel_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_done", 32'(bus.cpu_done_o), 32'd0);
    chk("rst_busy", 32'(bus.cpu_busy_o), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
    chk("rst_rdata", bus.cpu_rdata_o, 32'h0);

    // Cold miss then hit
    rd(32'h3, 32'h0000_1234);
    wait_done("cold_read");
    chk("cold_mem_reads", mem_rd_cnt, 1);
    rd(32'h3, 32'h0000_1234);
    chk("hit_latency_done", 32'(bus.cpu_done_o), 32'd1);
    chk("hit_no_mem_req", 32'(bus.mem_req_o), 32'd0);
    wait_done("hit_read");
    chk("hit_mem_reads", mem_rd_cnt, 1);
`ifdef DCACHE_STATS_EN
    chk("hits_after_first", hit_cnt, 32'd1);
    chk("misses_after_first", miss_cnt, 32'd1);
`else
    chk("hit_cnt_tied", hit_cnt, 32'd0);
    chk("miss_cnt_tied", miss_cnt, 32'd0);
`endif

    // Write miss does not allocate
    wr(32'h5, 32'hAABB_CCDD, 4'b1111);
    wait_done("write_miss");
    chk("write_miss_mem_writes", mem_wr_cnt, 1);
    rd(32'h5, 32'hAABB_CCDD);
    wait_done("read_after_write_miss");
    chk("no_write_allocate", mem_rd_cnt, 2);

    // Partial write hit merges
    rd(32'h2, 32'h1122_3344);
    wait_done("fill_line2");
    wr(32'h2, 32'h0000_EE00, 4'b0010);
    wait_done("partial_write");
    chk("partial_wsel", 32'(last_wsel), 32'h2);
    rd(32'h2, 32'h1122_EE44);
    wait_done("merged_read");
    chk("merged_read_hit", mem_rd_cnt, 3);

    // Simultaneous write and read to a cached line
    rd(32'h7, 32'h0);
    wait_done("fill_line7");
    sb.push_back('{is_read: 1'b1, data: 32'hDEAD_BEEF});
    issue(1'b1, 32'h7, 1'b1, 32'h7, 32'hDEAD_BEEF, 4'b1111);
    wait_done("pair");
    chk("pair_mem_writes", mem_wr_cnt, 3);
    chk("pair_no_mem_read", mem_rd_cnt, 4);

    // Aliasing lines
    rd(32'h01, 32'h0101_0101);
    rd(32'h11, 32'h1111_1111);
    rd(32'h01, 32'h0101_0101);
    wait_done("alias");
    chk("alias_mem_reads", mem_rd_cnt, 7);

    // Back-to-back hits
    @(negedge clk);
    sb.push_back('{is_read: 1'b1, data: 32'h0000_1234});
    bus.cpu_rreq_i = 1'b1; bus.cpu_raddr_i = 32'h3;
    @(negedge clk);
    chk("b2b_first_done", 32'(bus.cpu_done_o), 32'd1);
    sb.push_back('{is_read: 1'b1, data: 32'hAABB_CCDD});
    bus.cpu_raddr_i = 32'h5;
    @(negedge clk);
    chk("b2b_second_done", 32'(bus.cpu_done_o), 32'd1);
    bus.cpu_rreq_i = 1'b0;
    wait_done("b2b");

    // Zero byte-enable write still forwarded, line untouched
    wr(32'h3, 32'hFFFF_FFFF, 4'b0000);
    wait_done("wsel0");
    chk("wsel0_forwarded", mem_wr_cnt, 4);
    chk("wsel0_wsel", 32'(last_wsel), 32'h0);
    rd(32'h3, 32'h0000_1234);
    wait_done("wsel0_read");
    chk("wsel0_read_hit", mem_rd_cnt, 7);
`ifdef DCACHE_STATS_EN
    chk("hits_mid", hit_cnt, 32'd6);
    chk("misses_mid", miss_cnt, 32'd7);
`endif

    // Reset during an outstanding read; the late ack must be ignored
    lat = 6;
    issue(1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_mem_req", 32'(bus.mem_req_o), 32'd0);
    chk("rst_mid_busy", 32'(bus.cpu_busy_o), 32'd0);
    chk("rst_mid_rdata", bus.cpu_rdata_o, 32'h0);
    repeat (10) @(negedge clk);
    lat = 3;
    rd(32'h3, 32'h0000_1234);
    wait_done("after_reset_read");
    chk("after_reset_miss", mem_rd_cnt, 9);
`ifdef DCACHE_STATS_EN
    chk("hits_after_reset", hit_cnt, 32'd0);
    chk("misses_after_reset", miss_cnt, 32'd1);
`endif
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- CPU-facing data-cache responder. Serves the CPU data port (read/write requests, byte selects, read data) and forwards traffic to a simple single-outstanding memory port.
- Direct-mapped, one 32-bit word per line, write-through, no-write-allocate.
- Sits between the CPU data port and backing data RAM/bus; replaces the CPU's direct RAM hookup in the Dcache test benches.

Parameters:
INDEX_W, 4, line index bits; 2^INDEX_W lines (default 16).
TAG_W, 32-INDEX_W, tag width (derived, do not override).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
cpu_raddr_i  in  32  read word address (word-granular: index=addr[INDEX_W-1:0], tag=addr[31:INDEX_W])
cpu_rreq_i  in  1  read request
cpu_waddr_i  in  32  write word address
cpu_wdata_i  in  32  write data
cpu_wsel_i  in  4  byte enables for write, bit i = byte [8i+7:8i]
cpu_wreq_i  in  1  write request
cpu_rdata_o  out  32  read data, valid when cpu_done_o=1 for a read
cpu_done_o  out  1  one-cycle pulse: request (pair) complete
cpu_busy_o  out  1  high whenever state != IDLE; requests ignored while high
mem_req_o  out  1  memory request, held until mem_ack_i
mem_we_o  out  1  1=write, 0=read
mem_addr_o  out  32  memory word address
mem_wdata_o  out  32  memory write data
mem_wsel_o  out  4  memory byte enables
mem_rdata_i  in  32  memory read data, valid with mem_ack_i
mem_ack_i  in  1  one-cycle completion pulse
hit_cnt_o  out  32  read-hit counter (optional feature)
miss_cnt_o  out  32  read-miss counter (optional feature)

Behaviour:
- Reset: all outputs 0; all valid bits cleared; state IDLE; pending-read flag cleared. Reset mid-transaction drops mem_req_o next edge; any later mem_ack_i in IDLE is ignored.
- States: IDLE, WR_MEM, RD_MEM.
- Requests sampled only in IDLE. Addresses/data latched on acceptance; CPU may change inputs afterwards.
- IDLE, rreq only:
  - Hit (valid & tag match): cpu_rdata_o <= line data, cpu_done_o=1 next cycle (1-cycle latency). Stay IDLE; back-to-back hits accepted every cycle.
  - Miss: go RD_MEM; mem_req_o=1, mem_we_o=0, mem_addr_o=raddr.
- IDLE, wreq (with or without rreq):
  - Write hit: merge wdata into line per wsel; valid/tag unchanged. Write miss: cache untouched.
  - Go WR_MEM; mem_req_o=1, mem_we_o=1, addr/wdata/wsel forwarded unchanged.
  - Concurrent rreq: latch raddr and set pending-read. The read sees the just-written data on hit.
- wsel=0000: still forwarded to memory; no line change.
- WR_MEM on mem_ack_i:
  - Drop mem_req_o.
  - No pending read: cpu_done_o pulse, go IDLE.
  - Pending read hit: cpu_rdata_o <= line data, cpu_done_o pulse, go IDLE.
  - Pending read miss: go RD_MEM. No done pulse until the read completes.
- RD_MEM on mem_ack_i: fill line (valid=1, tag, data=mem_rdata_i); cpu_rdata_o <= mem_rdata_i; cpu_done_o pulse; go IDLE.
- Same-cycle ack and new request: request is not accepted; busy is still high that cycle.
- cpu_rdata_o holds its last value between reads. cpu_done_o is exactly one cycle per accepted request (pair).
- mem_* outputs stay stable while mem_req_o is high.

Optional Feature:
- DCACHE_STATS_EN defined:
  - hit_cnt_o increments on each read resolved from the cache, including a pending read after a write.
  - miss_cnt_o increments on each read that enters RD_MEM.
  - Both wrap at 2^32; both reset to 0.
- Undefined: no counter registers; hit_cnt_o and miss_cnt_o tied to 0.

Test Plan:
- Cold read addr 3, mem returns 0x0000_1234 after 3 cycles -> one mem read at addr 3; cpu_rdata_o=0x1234 with done; repeat read -> hit, done 1 cycle later, no mem_req_o; counters hits=1, misses=1.
- Write addr 5 data 0xAABBCCDD wsel 1111 (miss), then read addr 5 -> write forwarded, cache untouched, read misses and returns memory value 0xAABBCCDD.
- Line 2 cached 0x11223344, write wsel 0010 data 0x0000EE00 -> mem gets wsel 0010; next read hits, returns 0x1122EE44.
- Simultaneous wreq addr 7 (cached, data 0x0) / rreq addr 7, wdata 0xDEADBEEF -> memory write first, then single done with cpu_rdata_o=0xDEADBEEF, no mem read.
- Alias: read addr 0x01 fills line 1, read addr 0x11 (same index, tag differs) -> miss, refill; read addr 0x01 -> miss again.
- Assert rst during RD_MEM, then ack arrives -> mem_req_o low after reset edge, no done pulse; prior lines invalid (re-read misses).
